frame_config_writer: RTL and testbench

- Configuration-side master for one fabric column: the block that drives the tile configuration ports.
- Accepts a 32-bit word stream (valid/ready) and hunts for a sync word.
- Decodes per-frame headers and assembles one frame of data across all rows.
- Drives FrameData to the column's tiles, then fires a one-cycle one-hot FrameStrobe that latches the frame into the addressed config bits.

---
 rtl/frame_config_writer_if.sv | 17 +
 rtl/frame_config_writer.sv | 186 ++++++++++++++++++
 tb/tb_frame_config_writer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_config_writer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// frame_config_writer_if : 32-bit valid/ready word stream into the writer.
// Rev 1.0
// ---------------------------------------------------------------------------
interface frame_config_writer_if #(
  parameter int FrameBitsPerRow = 32
);
  logic [FrameBitsPerRow-1:0] s_data;
  logic                       s_valid;
  logic                       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/frame_config_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// frame_config_writer : sync/header/data stream -> FrameData + FrameStrobe.
// Optional check-word stage: FRAME_CONFIG_CRC_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module frame_config_writer #(
  parameter int                         FrameBitsPerRow = 32,
  parameter int                         MaxFramesPerCol = 20,
  parameter int                         NumRows         = 16,
  parameter logic [FrameBitsPerRow-1:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  wire logic                                UserCLK,
  input  wire logic                                resetn,
  frame_config_writer_if.slave                     s_if,
  output logic [NumRows*FrameBitsPerRow-1:0]       FrameData,
  output logic [MaxFramesPerCol-1:0]               FrameStrobe,
  output logic [15:0]                              frames_written,
  output logic                                     cfg_active,
  output logic                                     err
);

  localparam int              CntW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [CntW-1:0] LastRow = CntW'(NumRows - 1);
  localparam logic [8:0]      IdxLim  = 9'(MaxFramesPerCol);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_STROBE = 3'd3,
    ST_CHECK  = 3'd4
  } state_t;

  state_t                               state_q, state_d;
  logic [7:0]                           idx_q, idx_d;
  logic [CntW-1:0]                      cnt_q, cnt_d;
  logic                                 drop_q, drop_d;
  logic [NumRows*FrameBitsPerRow-1:0]   data_q, data_d;
  logic [15:0]                          frames_q, frames_d;
  logic                                 active_q, active_d;
  logic                                 err_q, err_d;
`ifdef FRAME_CONFIG_CRC_EN
  logic [FrameBitsPerRow-1:0]           crc_q, crc_d;
`endif

  logic                                 ready;
  logic                                 hs;
  logic [FrameBitsPerRow-1:0]           word;
  logic [MaxFramesPerCol-1:0]           strobe;

  assign word  = s_if.s_data;
  assign ready = (state_q != ST_STROBE);
  assign hs    = s_if.s_valid & ready;

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      data_q   <= '0;
      frames_q <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef FRAME_CONFIG_CRC_EN
      crc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      data_q   <= data_d;
      frames_q <= frames_d;
      active_q <= active_d;
      err_q    <= err_d;
`ifdef FRAME_CONFIG_CRC_EN
      crc_q    <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    data_d   = data_q;
    frames_d = frames_q;
    active_d = active_q;
    err_d    = err_q;
`ifdef FRAME_CONFIG_CRC_EN
    crc_d    = crc_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (hs && (word == SyncWord)) begin
          state_d  = ST_HEADER;
          active_d = 1'b1;
        end
      end

      ST_HEADER: begin
        if (hs) begin
          if (word[31]) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
          end else begin
            state_d = ST_DATA;
            idx_d   = word[7:0];
            cnt_d   = '0;
            drop_d  = ({1'b0, word[7:0]} >= IdxLim);
            if ({1'b0, word[7:0]} >= IdxLim) begin
              err_d = 1'b1;
            end
`ifdef FRAME_CONFIG_CRC_EN
            crc_d = word;
`endif
          end
        end
      end

      ST_DATA: begin
        if (hs) begin
          data_d[cnt_q*FrameBitsPerRow +: FrameBitsPerRow] = word;
          cnt_d = cnt_q + CntW'(1);
`ifdef FRAME_CONFIG_CRC_EN
          crc_d = crc_q ^ word;
          if (cnt_q == LastRow) begin
            state_d = ST_CHECK;
          end
`else
          if (cnt_q == LastRow) begin
            state_d = drop_q ? ST_HEADER : ST_STROBE;
          end
`endif
        end
      end

      ST_STROBE: begin
        frames_d = frames_q + 16'd1;
        state_d  = ST_HEADER;
      end

`ifdef FRAME_CONFIG_CRC_EN
      ST_CHECK: begin
        // A dropped frame eats its check word but never strobes.
        if (hs) begin
          if ((word == crc_q) && !drop_q) begin
            state_d = ST_STROBE;
          end else begin
            state_d = ST_HEADER;
            if (word != crc_q) begin
              err_d = 1'b1;
            end
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    strobe = '0;
    if ((state_q == ST_STROBE) && !drop_q) begin
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        strobe[i] = (idx_q == 8'(i));
      end
    end
  end

  assign s_if.s_ready   = ready;
  assign FrameData      = data_q;
  assign FrameStrobe    = strobe;
  assign frames_written = frames_q;
  assign cfg_active     = active_q;
  assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_config_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_frame_config_writer : directed vector table plus multi-cycle sequences.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_frame_config_writer;

  localparam int          W    = 32;
  localparam int          NF   = 20;
  localparam int          NR   = 16;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
`ifdef FRAME_CONFIG_CRC_EN
  localparam int          XTRA = 1;
`else
  localparam int          XTRA = 0;
`endif

  logic UserCLK = 1'b0;
  logic resetn  = 1'b0;

  frame_config_writer_if #(.FrameBitsPerRow(W)) bus ();

  logic [NR*W-1:0] FrameData;
  logic [NF-1:0]   FrameStrobe;
  logic [15:0]     frames_written;
  logic            cfg_active;
  logic            err;

  frame_config_writer #(
    .FrameBitsPerRow(W), .MaxFramesPerCol(NF), .NumRows(NR), .SyncWord(SYNC)
  ) dut (
    .UserCLK       (UserCLK),
    .resetn        (resetn),
    .s_if          (bus),
    .FrameData     (FrameData),
    .FrameStrobe   (FrameStrobe),
    .frames_written(frames_written),
    .cfg_active    (cfg_active),
    .err           (err)
  );

  always #5 UserCLK = ~UserCLK;

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0, hs_cyc = 0, strobe_cyc = -1, strobe_hits = 0;
  logic          hs;
  logic          obs_ready, obs_active, obs_err;
  logic [NF-1:0] obs_strobe;

  typedef struct {
    logic          v;
    logic [31:0]   d;
    logic [NF-1:0] strobe;
    logic          ready;
    logic          active;
    logic          err_e;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, observe on the falling edge.
  task automatic step(input logic v, input logic [31:0] d);
    bus.s_valid = v;
    bus.s_data  = d;
    @(negedge UserCLK);
    obs_ready  = bus.s_ready;
    obs_strobe = FrameStrobe;
    obs_active = cfg_active;
    obs_err    = err;
    hs         = v && bus.s_ready;
    if (hs) hs_cyc = cyc;
    if (FrameStrobe != '0) begin
      strobe_hits++;
      strobe_cyc = cyc;
    end
    @(posedge UserCLK);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    do begin
      step(1'b1, d);
      n++;
    end while (!hs && n < 8);
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_handshake required=handshake word=%h", d);
    end
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base,
                            input int stall_after, input int stall_len,
                            output int hdr_cyc);
    logic [31:0] x;
    x = hdr;
    send(hdr);
    hdr_cyc = hs_cyc;
    for (int k = 0; k < NR; k++) begin
      send(base + 32'(k));
      x = x ^ (base + 32'(k));
      if (k == stall_after) repeat (stall_len) step(1'b0, 32'd0);
    end
`ifdef FRAME_CONFIG_CRC_EN
    send(x);
`endif
  endtask

  task automatic push(input logic v, input logic [31:0] d, input logic [NF-1:0] s,
                      input logic r, input logic a, input logic e);
    vec_t t;
    t.v = v; t.d = d; t.strobe = s; t.ready = r; t.active = a; t.err_e = e;
    tbl.push_back(t);
  endtask

  initial begin
    int          hc;
    int          hits0;
    logic [31:0] x;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(posedge UserCLK);
    #1;
    chk("rst_ready",  32'(bus.s_ready), 32'd1);
    chk("rst_fdata",  32'(|FrameData), 32'd0);
    chk("rst_strobe", 32'(FrameStrobe), 32'd0);
    chk("rst_frames", 32'(frames_written), 32'd0);
    chk("rst_active", 32'(cfg_active), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    @(negedge UserCLK);
    resetn = 1'b1;
    @(posedge UserCLK);
    #1;

    // Vector table: junk, sync, header idx 3, 16 data words, strobe, idle.
    x = 32'h0000_0003;
    push(1'b1, 32'h1234_5678, '0, 1'b1, 1'b0, 1'b0);
    push(1'b1, SYNC,          '0, 1'b1, 1'b0, 1'b0);
    push(1'b1, 32'h0000_0003, '0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < NR; k++) begin
      push(1'b1, 32'h1000 + 32'(k), '0, 1'b1, 1'b1, 1'b0);
      x = x ^ (32'h1000 + 32'(k));
    end
`ifdef FRAME_CONFIG_CRC_EN
    push(1'b1, x, '0, 1'b1, 1'b1, 1'b0);
`endif
    push(1'b0, 32'd0, 20'h00008, 1'b0, 1'b1, 1'b0);
    push(1'b0, 32'd0, 20'h00000, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d_ready", i),  32'(obs_ready),  32'(tbl[i].ready));
      chk($sformatf("vec%0d_strobe", i), 32'(obs_strobe), 32'(tbl[i].strobe));
      chk($sformatf("vec%0d_active", i), 32'(obs_active), 32'(tbl[i].active));
      chk($sformatf("vec%0d_err", i),    32'(obs_err),    32'(tbl[i].err_e));
    end
    chk("vec_frames", 32'(frames_written), 32'd1);
    for (int k = 0; k < NR; k++)
      chk($sformatf("vec_slice%0d", k), FrameData[k*W +: W], 32'h1000 + 32'(k));

    // Bad index frame is dropped, next frame strobes bit 0, err stays set.
    hits0 = strobe_hits;
    send_frame(32'h0000_0014, 32'h5000, -1, 0, hc);
    chk("drop_err",      32'(err), 32'd1);
    chk("drop_nostrobe", 32'(strobe_hits - hits0), 32'd0);
    send_frame(32'h0000_0000, 32'h2000, -1, 0, hc);
    step(1'b0, 32'd0);
    chk("f0_strobe", 32'(obs_strobe), 32'h1);
    chk("f0_ready",  32'(obs_ready), 32'd0);
    step(1'b0, 32'd0);
    chk("f0_width",  32'(obs_strobe), 32'd0);
    chk("f0_err",    32'(err), 32'd1);
    chk("f0_frames", 32'(frames_written), 32'd2);
    chk("f0_slice0",  FrameData[0 +: W], 32'h2000);
    chk("f0_slice15", FrameData[15*W +: W], 32'h200F);

    // Five idle cycles after data word 7 delay the strobe by five cycles.
    send_frame(32'h0000_0005, 32'h3000, 7, 5, hc);
    step(1'b0, 32'd0);
    chk("stall_strobe",  32'(obs_strobe), 32'h20);
    chk("stall_latency", 32'(strobe_cyc - hc), 32'(NR + 1 + 5 + XTRA));
    step(1'b0, 32'd0);
    chk("stall_frames", 32'(frames_written), 32'd3);
    for (int k = 0; k < NR; k++)
      chk($sformatf("stall_slice%0d", k), FrameData[k*W +: W], 32'h3000 + 32'(k));

    // Reset after data word 9 aborts the frame.
    send(32'h0000_0007);
    for (int k = 0; k < 10; k++) send(32'h4000 + 32'(k));
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_fdata",  32'(|FrameData), 32'd0);
    chk("arst_strobe", 32'(FrameStrobe), 32'd0);
    chk("arst_frames", 32'(frames_written), 32'd0);
    chk("arst_active", 32'(cfg_active), 32'd0);
    chk("arst_err",    32'(err), 32'd0);
    chk("arst_ready",  32'(bus.s_ready), 32'd1);
    hits0 = strobe_hits;
    repeat (2) step(1'b0, 32'd0);
    @(negedge UserCLK);
    resetn = 1'b1;
    @(posedge UserCLK);
    #1;
    send_frame(32'h0000_0002, 32'h6000, -1, 0, hc);
    repeat (2) step(1'b0, 32'd0);
    chk("idle_nostrobe", 32'(strobe_hits - hits0), 32'd0);
    chk("idle_active",   32'(cfg_active), 32'd0);
    chk("idle_frames",   32'(frames_written), 32'd0);
    chk("idle_fdata",    32'(|FrameData), 32'd0);

    // Desync header: cfg_active drops the cycle after its handshake.
    send(SYNC);
    step(1'b0, 32'd0);
    chk("sync_active", 32'(obs_active), 32'd1);
    send(32'h8000_0000);
    chk("desync_pre", 32'(obs_active), 32'd1);
    step(1'b0, 32'd0);
    chk("desync_post", 32'(obs_active), 32'd0);
    chk("desync_err",  32'(err), 32'd0);

`ifdef FRAME_CONFIG_CRC_EN
    // Wrong check word: error, no strobe. Correct one: strobe.
    send(SYNC);
    hits0 = strobe_hits;
    x = 32'h0000_0004;
    send(x);
    for (int k = 0; k < NR; k++) begin
      send(32'h7000 + 32'(k));
      x = x ^ (32'h7000 + 32'(k));
    end
    send(~x);
    step(1'b0, 32'd0);
    step(1'b0, 32'd0);
    chk("crc_bad_nostrobe", 32'(strobe_hits - hits0), 32'd0);
    chk("crc_bad_err",      32'(err), 32'd1);
    send_frame(32'h0000_0004, 32'h7100, -1, 0, hc);
    step(1'b0, 32'd0);
    chk("crc_good_strobe", 32'(obs_strobe), 32'h10);
    step(1'b0, 32'd0);
    chk("crc_good_frames", 32'(frames_written), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
